// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with programmable threshold flags, occupancy count, sticky
// overflow/underflow, synchronous clear and a selectable FWFT read port.
module fifo_sync_flags #(
    parameter int NB_DATA  = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_clear,
    input  logic                     i_wr_en,
    input  logic [NB_DATA-1:0]       i_data,
    input  logic                     i_rd_en,
    output logic [NB_DATA-1:0]       o_data,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_almost_full,
    output logic                     o_almost_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [NB_DATA-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               full;
    logic               empty;
    logic               wr_ok;
    logic               rd_ok;
    logic               wr_err;
    logic               rd_err;

    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] c,
                                                 input logic w,
                                                 input logic r);
        case ({w, r})
            2'b10:   return c + 1'b1;
            2'b01:   return c - 1'b1;
            default: return c;
        endcase
    endfunction

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A clear cycle swallows both requests and raises no error.
    always_comb begin
        wr_ok  = i_wr_en & ~full  & ~i_clear;
        rd_ok  = i_rd_en & ~empty & ~i_clear;
        wr_err = i_wr_en &  full  & ~i_clear;
        rd_err = i_rd_en &  empty & ~i_clear;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (i_clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= next_count(count, wr_ok, rd_ok);
            if (wr_err) o_overflow  <= 1'b1;
            if (rd_err) o_underflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) mem[wr_ptr] <= i_data;
    end

    assign o_full         = full;
    assign o_empty        = empty;
    assign o_almost_full  = (count >= AF_C);
    assign o_almost_empty = (count <= AE_C);
    assign o_count        = count;

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; i_rd_en only acknowledges it.
            assign o_valid = ~empty;
            assign o_data  = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [NB_DATA-1:0] rd_data_p1;
            logic               vld_p1;

            // ---- stage p1: registered read port ----
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    rd_data_p1 <= '0;
                    vld_p1     <= 1'b0;
                end else begin
                    vld_p1 <= rd_ok;
                    if (rd_ok) rd_data_p1 <= mem[rd_ptr];
                end
            end

            assign o_valid = vld_p1;
            assign o_data  = rd_data_p1;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed scoreboard bench for fifo_sync_flags in standard and FWFT read modes.
module tb_fifo_sync_flags;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       s_clr = 1'b0, s_wr = 1'b0, s_rd = 1'b0;
    logic [3:0] s_din = '0;
    logic [3:0] s_dout;
    logic       s_vld, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [3:0] s_cnt;

    logic       f_clr = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
    logic [3:0] f_din = '0;
    logic [3:0] f_dout;
    logic       f_vld, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [3:0] f_cnt;

    int vectors = 0;
    int miscompares = 0;

    // model state for the standard-mode instance
    logic [3:0] mem_q[$];
    logic [3:0] exp_q[$];
    int         mcount = 0;
    logic       movf = 1'b0, mudf = 1'b0;
    logic [3:0] f_q[$];

    always #5 clk = ~clk;

    fifo_sync_flags #(.NB_DATA(4), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut_std (
        .i_clk(clk), .i_reset_n(rst_n), .i_clear(s_clr), .i_wr_en(s_wr), .i_data(s_din),
        .i_rd_en(s_rd), .o_data(s_dout), .o_valid(s_vld), .o_full(s_full), .o_empty(s_empty),
        .o_almost_full(s_af), .o_almost_empty(s_ae), .o_count(s_cnt),
        .o_overflow(s_ovf), .o_underflow(s_udf)
    );

    fifo_sync_flags #(.NB_DATA(4), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut_fw (
        .i_clk(clk), .i_reset_n(rst_n), .i_clear(f_clr), .i_wr_en(f_wr), .i_data(f_din),
        .i_rd_en(f_rd), .o_data(f_dout), .o_valid(f_vld), .o_full(f_full), .o_empty(f_empty),
        .o_almost_full(f_af), .o_almost_empty(f_ae), .o_count(f_cnt),
        .o_overflow(f_ovf), .o_underflow(f_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_std_reset(input string tag);
        chk({tag, "_data"},  32'(s_dout),  32'h0);
        chk({tag, "_valid"}, 32'(s_vld),   32'h0);
        chk({tag, "_full"},  32'(s_full),  32'h0);
        chk({tag, "_empty"}, 32'(s_empty), 32'h1);
        chk({tag, "_ae"},    32'(s_ae),    32'h1);
        chk({tag, "_af"},    32'(s_af),    32'h0);
        chk({tag, "_count"}, 32'(s_cnt),   32'h0);
        chk({tag, "_ovf"},   32'(s_ovf),   32'h0);
        chk({tag, "_udf"},   32'(s_udf),   32'h0);
    endtask

    // One clock of the standard instance: drive, predict, clock, compare.
    task automatic cyc(input logic wr, input logic [3:0] din, input logic rd, input logic clr,
                       input string tag);
        logic wr_ok, rd_ok;
        s_wr = wr; s_din = din; s_rd = rd; s_clr = clr;
        wr_ok = 1'b0; rd_ok = 1'b0;
        if (clr) begin
            mem_q.delete();
            mcount = 0; movf = 1'b0; mudf = 1'b0;
        end else begin
            wr_ok = wr && (mcount < 8);
            rd_ok = rd && (mcount > 0);
            if (wr && !wr_ok) movf = 1'b1;
            if (rd && !rd_ok) mudf = 1'b1;
            if (rd_ok) exp_q.push_back(mem_q.pop_front());
            if (wr_ok) mem_q.push_back(din);
            mcount = mcount + int'(wr_ok) - int'(rd_ok);
        end
        @(posedge clk); #1;
        s_wr = 1'b0; s_rd = 1'b0; s_clr = 1'b0;
        chk({tag, "_count"}, 32'(s_cnt),   32'(mcount));
        chk({tag, "_full"},  32'(s_full),  32'(mcount == 8));
        chk({tag, "_empty"}, 32'(s_empty), 32'(mcount == 0));
        chk({tag, "_af"},    32'(s_af),    32'(mcount >= 6));
        chk({tag, "_ae"},    32'(s_ae),    32'(mcount <= 2));
        chk({tag, "_ovf"},   32'(s_ovf),   32'(movf));
        chk({tag, "_udf"},   32'(s_udf),   32'(mudf));
        chk({tag, "_valid"}, 32'(s_vld),   32'(rd_ok));
        if (s_vld === 1'b1 && exp_q.size() > 0)
            chk({tag, "_data"}, 32'(s_dout), 32'(exp_q.pop_front()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_std_reset("rst");
        chk("rst_fw_valid", 32'(f_vld),   32'h0);
        chk("rst_fw_data",  32'(f_dout),  32'h0);
        chk("rst_fw_empty", 32'(f_empty), 32'h1);
        rst_n = 1'b1;

        // Fill 1..8, then a dropped 9th write
        for (int i = 1; i <= 8; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0, $sformatf("fill%0d", i));
        cyc(1'b1, 4'd9, 1'b0, 1'b0, "ovf");

        // Drain with 9 reads in standard mode, then an idle cycle
        for (int i = 1; i <= 9; i++) cyc(1'b0, 4'd0, 1'b1, 1'b0, $sformatf("drain%0d", i));
        cyc(1'b0, 4'd0, 1'b0, 1'b0, "idle");

        // Wrap and concurrency
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'(i + 3), 1'b0, 1'b0, $sformatf("pre%0d", i));
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 4'((i + 8) & 15), 1'b1, 1'b0, $sformatf("wrap%0d", i));

        // Clear with count=4 and a pending write
        cyc(1'b0, 4'd0, 1'b1, 1'b0, "to4");
        cyc(1'b1, 4'd7, 1'b0, 1'b1, "clear");
        cyc(1'b0, 4'd0, 1'b0, 1'b0, "postclr");

        // Async reset mid-stream with count=3
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i + 12), 1'b0, 1'b0, $sformatf("ar%0d", i));
        cyc(1'b0, 4'd0, 1'b1, 1'b0, "ar_rd");
        cyc(1'b1, 4'd2, 1'b0, 1'b0, "ar_wr");
        #3;
        rst_n = 1'b0;
        #1;
        chk_std_reset("arst");
        mem_q.delete(); exp_q.delete();
        mcount = 0; movf = 1'b0; mudf = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // FWFT: head word visible one cycle after the write
        f_wr = 1'b1; f_din = 4'hA; f_q.push_back(4'hA);
        @(posedge clk); #1;
        f_wr = 1'b0;
        chk("fw_valid", 32'(f_vld), 32'h1);
        chk("fw_data",  32'(f_dout), 32'(f_q[0]));
        chk("fw_count", 32'(f_cnt), 32'h1);
        f_rd = 1'b1; void'(f_q.pop_front());
        @(posedge clk); #1;
        f_rd = 1'b0;
        chk("fw_empty",   32'(f_empty), 32'h1);
        chk("fw_valid0",  32'(f_vld),   32'h0);
        chk("fw_data0",   32'(f_dout),  32'h0);

        // FWFT: acknowledge advances to the next head word
        f_wr = 1'b1; f_din = 4'h3; f_q.push_back(4'h3);
        @(posedge clk); #1;
        f_din = 4'h5; f_q.push_back(4'h5);
        @(posedge clk); #1;
        f_wr = 1'b0;
        chk("fw_head1", 32'(f_dout), 32'(f_q.pop_front()));
        f_rd = 1'b1;
        @(posedge clk); #1;
        f_rd = 1'b0;
        chk("fw_head2", 32'(f_dout), 32'(f_q.pop_front()));
        chk("fw_cnt1",  32'(f_cnt),  32'h1);
        chk("fw_udf",   32'(f_udf),  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
